// File: rtl/combine_sched_if.sv
// Bundle of client request/response and engine-side signals for combine_sched.
// slave is the scheduler's view; master is the clients plus the combine engine.
interface combine_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_mode;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*WIDTH-1:0] req_c;
    logic [NREQ*WIDTH-1:0] req_d;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  rsp_timeout;
    logic                  eng_reset;
    logic                  eng_start;
    logic                  eng_mode;
    logic [WIDTH-1:0]      eng_a;
    logic [WIDTH-1:0]      eng_b;
    logic [WIDTH-1:0]      eng_c;
    logic [WIDTH-1:0]      eng_d;
    logic [WIDTH-1:0]      eng_result;
    logic                  eng_done;

    modport slave (
        input  req, req_mode, req_a, req_b, req_c, req_d, eng_result, eng_done,
        output gnt, rsp_valid, rsp_id, rsp_result, rsp_timeout,
        output eng_reset, eng_start, eng_mode, eng_a, eng_b, eng_c, eng_d
    );

    modport master (
        output req, req_mode, req_a, req_b, req_c, req_d, eng_result, eng_done,
        input  gnt, rsp_valid, rsp_id, rsp_result, rsp_timeout,
        input  eng_reset, eng_start, eng_mode, eng_a, eng_b, eng_c, eng_d
    );
endinterface

// File: rtl/combine_sched.sv
// Round-robin scheduler sharing one combine engine among NREQ requesters,
// with a per-job watchdog that aborts a job whose engine never signals done.
module combine_sched #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input logic             clock,
    input logic             reset,
    combine_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [7:0]     CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   win;
    logic             any_req;
    logic             grant;
    logic [7:0]       cnt;
    logic             wait_done;
    logic             wait_tmo;

    logic             mode_q;
    logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
    logic [WIDTH-1:0] res_q;
    logic [IDW-1:0]   rsp_id_q;
    logic             tmo_q;

    logic [NREQ-1:0]  gnt_c;
    logic             rsp_valid_c;
    logic             eng_reset_c;
    logic             eng_start_c;

    // Descending scan so the smallest offset from ptr is the last (winning) hit.
    always_comb begin
        int k;
        k       = 0;
        win     = ptr;
        any_req = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (bus.req[k]) begin
                win     = IDW'(k);
                any_req = 1'b1;
            end
        end
    end

    assign grant     = (state == IDLE) && any_req;
    assign wait_done = (state == WAIT) && bus.eng_done;
    assign wait_tmo  = (state == WAIT) && !bus.eng_done && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            id_q  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                id_q <= win;
            end
            if (state == LAUNCH) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 8'd1;
            end
            if (state == RESP) begin
                ptr <= (id_q == ID_LAST) ? '0 : id_q + IDW'(1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_c       = '0;
        rsp_valid_c = 1'b0;
        eng_reset_c = 1'b0;
        eng_start_c = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                eng_reset_c = 1'b1;
                state_nxt   = LAUNCH;
            end
            LAUNCH: begin
                eng_start_c = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                eng_start_c = 1'b1;
                if (wait_done || wait_tmo) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                eng_reset_c = 1'b1;
                rsp_valid_c = 1'b1;
                gnt_c[id_q] = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands are captured only at the grant; later changes on req_* are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            res_q    <= '0;
            rsp_id_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (grant) begin
                mode_q <= bus.req_mode[win];
                a_q    <= bus.req_a[win*WIDTH +: WIDTH];
                b_q    <= bus.req_b[win*WIDTH +: WIDTH];
                c_q    <= bus.req_c[win*WIDTH +: WIDTH];
                d_q    <= bus.req_d[win*WIDTH +: WIDTH];
            end
            if (wait_done || wait_tmo) begin
                res_q    <= wait_done ? bus.eng_result : '0;
                tmo_q    <= wait_tmo;
                rsp_id_q <= id_q;
            end
        end
    end

    assign bus.gnt         = gnt_c;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_result  = res_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.eng_reset   = eng_reset_c;
    assign bus.eng_start   = eng_start_c;
    assign bus.eng_mode    = mode_q;
    assign bus.eng_a       = a_q;
    assign bus.eng_b       = b_q;
    assign bus.eng_c       = c_q;
    assign bus.eng_d       = d_q;
endmodule
